// File: rtl/pixel_readout_pkg.sv
// Shared constants and types for the pixel readout stage: default geometry,
// capture FSM states and the layout of one serialized FIFO entry.
package pixel_readout_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_N_PIX      = 4;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_PIX_W      = $clog2(DEF_N_PIX);

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_PUSH = 1'b1
    } cap_state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_PIX_W-1:0]  pix;
        logic                  sof;
    } fifo_entry_t;

endpackage

// File: rtl/readout_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rdata whenever the
// FIFO is not empty, and a push into a full FIFO is accepted when a pop coincides.
module readout_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Readout stage behind the pixel array FSM: analog enables, saturating ramp DAC
// code, and a one-shot capture of all pixel buses serialized into a stream FIFO.
module pixel_readout_ctrl
    import pixel_readout_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int N_PIX      = DEF_N_PIX,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      erase,
    input  logic                      expose,
    input  logic                      convert,
    input  logic                      read,
    input  logic [N_PIX*DATA_W-1:0]   pix_data,
    output logic                      ramp_en,
    output logic                      bias_en,
    output logic                      bus_oe,
    output logic [DATA_W-1:0]         dac_data,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(N_PIX)-1:0]  out_pix,
    output logic                      out_sof,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               frame_cnt,
    output logic                      overflow
);

    localparam int                PIX_W    = $clog2(N_PIX);
    localparam int                ENTRY_W  = DATA_W + PIX_W + 1;
    localparam logic [DATA_W-1:0] DAC_MAX  = '1;
    localparam logic [PIX_W-1:0]  LAST_IDX = PIX_W'(N_PIX - 1);

    cap_state_e        state_q, state_d;
    logic [PIX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] capture_q [N_PIX];
    logic [DATA_W-1:0] capture_d [N_PIX];
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              overflow_q, overflow_d;
    logic              read_q;
    logic [DATA_W-1:0] dac_q, dac_d;

    logic               read_rise;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] pop_entry;
    logic               unused_erase;

    // The erase phase needs no action from this stage.
    assign unused_erase = erase;

    assign ramp_en   = convert;
    assign bias_en   = expose;
    assign bus_oe    = !read;
    assign dac_data  = dac_q;
    assign frame_cnt = frame_cnt_q;
    assign overflow  = overflow_q;
    assign read_rise = read && !read_q;
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign {out_data, out_pix, out_sof} = pop_entry;

    always_comb begin
        if (!convert) begin
            dac_d = '0;
        end else if (dac_q == DAC_MAX) begin
            dac_d = dac_q;
        end else begin
            dac_d = dac_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        capture_d   = capture_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q;
        fifo_push   = 1'b0;
        push_entry  = {capture_q[idx_q], idx_q, (idx_q == '0)};

        case (state_q)
            CAP_IDLE: begin
                if (read_rise) begin
                    for (int i = 0; i < N_PIX; i++) begin
                        capture_d[i] = pix_data[i*DATA_W +: DATA_W];
                    end
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    idx_d       = '0;
                    state_d     = CAP_PUSH;
                end
            end
            CAP_PUSH: begin
                fifo_push = 1'b1;
                // A sample lost to a full FIFO or a frame lost to a busy capture
                // both mean the frame buffer saw incomplete data.
                if (fifo_full && !fifo_pop) overflow_d = 1'b1;
                if (read_rise)              overflow_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = CAP_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CAP_IDLE;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
            read_q      <= 1'b0;
            dac_q       <= '0;
            for (int i = 0; i < N_PIX; i++) begin
                capture_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
            read_q      <= read;
            dac_q       <= dac_d;
            capture_q   <= capture_d;
        end
    end

    readout_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (pop_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed and randomized bench for pixel_readout_ctrl against a queue-based
// behavioural model of the ramp counter, frame capture and stream FIFO.
module tb_pixel_readout_ctrl;

    localparam int DATA_W     = 8;
    localparam int N_PIX      = 4;
    localparam int FIFO_DEPTH = 8;

    logic                    clk       = 1'b0;
    logic                    reset     = 1'b0;
    logic                    erase     = 1'b0;
    logic                    expose    = 1'b0;
    logic                    convert   = 1'b0;
    logic                    read      = 1'b0;
    logic                    out_ready = 1'b0;
    logic [N_PIX*DATA_W-1:0] pix_data  = '0;
    logic                    ramp_en, bias_en, bus_oe;
    logic [DATA_W-1:0]       dac_data, out_data;
    logic [1:0]              out_pix;
    logic                    out_sof, out_valid, overflow;
    logic [15:0]             frame_cnt;

    typedef struct {
        int data;
        int pix;
        int sof;
    } sample_t;

    sample_t fifoQ[$];
    sample_t pendQ[$];
    int      mDac, mFrame, mOvf, mReadQ;
    int      nCompared   = 0;
    int      nMismatched = 0;
    int      obsPops     = 0;

    always #5 clk = ~clk;

    pixel_readout_ctrl #(
        .DATA_W     (DATA_W),
        .N_PIX      (N_PIX),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .erase     (erase),
        .expose    (expose),
        .convert   (convert),
        .read      (read),
        .pix_data  (pix_data),
        .ramp_en   (ramp_en),
        .bias_en   (bias_en),
        .bus_oe    (bus_oe),
        .dac_data  (dac_data),
        .out_data  (out_data),
        .out_pix   (out_pix),
        .out_sof   (out_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt),
        .overflow  (overflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        fifoQ.delete();
        pendQ.delete();
        mDac   = 0;
        mFrame = 0;
        mOvf   = 0;
        mReadQ = 0;
    endtask

    task automatic checkAll();
        checkOutput("out_valid", out_valid, (fifoQ.size() > 0) ? 1 : 0);
        if (fifoQ.size() > 0) begin
            checkOutput("out_data", out_data, fifoQ[0].data);
            checkOutput("out_pix",  out_pix,  fifoQ[0].pix);
            checkOutput("out_sof",  out_sof,  fifoQ[0].sof);
        end
        checkOutput("dac_data",  dac_data,  mDac);
        checkOutput("frame_cnt", frame_cnt, mFrame);
        checkOutput("overflow",  overflow,  mOvf);
        checkOutput("ramp_en",   ramp_en,   convert);
        checkOutput("bias_en",   bias_en,   expose);
        checkOutput("bus_oe",    bus_oe,    !read);
    endtask

    // Advance the model by one rising edge using the inputs as they stand, then
    // let the DUT take the same edge and compare just after it.
    task automatic step();
        sample_t s;
        bit      pop, busy;
        if (out_valid && out_ready) obsPops++;
        if (reset) begin
            pop  = (fifoQ.size() > 0) && out_ready;
            busy = (pendQ.size() > 0);
            if (busy) s = pendQ.pop_front();
            if (read && (mReadQ == 0)) begin
                if (busy) begin
                    mOvf = 1;
                end else begin
                    for (int i = 0; i < N_PIX; i++) begin
                        pendQ.push_back('{int'(pix_data[i*DATA_W +: DATA_W]), i, (i == 0) ? 1 : 0});
                    end
                    mFrame = (mFrame + 1) % 65536;
                end
            end
            if (pop) void'(fifoQ.pop_front());
            if (busy) begin
                if (fifoQ.size() < FIFO_DEPTH) fifoQ.push_back(s);
                else mOvf = 1;
            end
            mDac   = convert ? ((mDac < 255) ? mDac + 1 : 255) : 0;
            mReadQ = read ? 1 : 0;
        end
        @(posedge clk);
        #1;
        if (!reset) modelReset();
        checkAll();
    endtask

    task automatic applyStimulus(input logic c, input logic e, input logic r, input logic rdy);
        convert   = c;
        expose    = e;
        read      = r;
        out_ready = rdy;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_pix",  out_pix,  0);
        checkOutput("rst_out_sof",  out_sof,  0);
        erase = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
    endtask

    initial begin
        // Power-on reset.
        modelReset();
        #2;
        checkAll();
        checkOutput("por_out_data", out_data, 0);
        step();
        reset = 1'b1;
        step();

        // Ramp counts up, saturates at 255, clears one edge after convert drops.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step();
        checkOutput("dac_saturated", dac_data, 255);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("dac_cleared", dac_data, 0);

        // Asynchronous reset in the middle of a conversion.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 37; i++) step();
        checkOutput("dac_at_37", dac_data, 37);
        applyReset();
        step();
        checkOutput("post_rst_dac",   dac_data,  0);
        checkOutput("post_rst_valid", out_valid, 0);

        // One frame with known pixel values, read held for five cycles.
        pix_data = 32'h44332211;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        checkOutput("latency_edge_k", out_valid, 0);
        step();
        checkOutput("latency_edge_k1", out_valid, 1);
        checkOutput("first_sample",    out_data,  8'h11);
        checkOutput("first_sof",       out_sof,   1);
        for (int i = 0; i < 3; i++) step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        checkOutput("one_frame_cnt", frame_cnt, 1);

        // Three frames into a stalled stream: only the first eight samples survive.
        applyReset();
        for (int f = 0; f < 3; f++) begin
            pix_data = $urandom;
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            step();
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) step();
        end
        checkOutput("stall_overflow", overflow,  1);
        checkOutput("stall_frames",   frame_cnt, 3);
        obsPops = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step();
        checkOutput("drain_count", obsPops, 8);

        // Pop and push together at 8/8 and at 7/8 occupancy: nothing dropped.
        applyReset();
        for (int f = 0; f < 2; f++) begin
            pix_data = $urandom;
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            step();
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) step();
        end
        pix_data = $urandom;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        pix_data = $urandom;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        checkOutput("simul_no_overflow", overflow, 0);
        for (int i = 0; i < 10; i++) step();
        checkOutput("simul_drained", out_valid, 0);

        // A second read rise while the first frame is still being pushed.
        applyReset();
        obsPops  = 0;
        pix_data = $urandom;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        pix_data = $urandom;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step();
        checkOutput("busy_overflow", overflow,  1);
        checkOutput("busy_frames",   frame_cnt, 1);
        checkOutput("busy_samples",  obsPops,   4);

        // Random phase strobes, pixel data and back-pressure.
        applyReset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int ph;
                ph    = $urandom_range(0, 4);
                erase = (ph == 1);
                applyStimulus(ph == 3, ph == 2, ph == 4, out_ready);
            end
            pix_data  = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        erase = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step();
        checkOutput("random_drained", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
